// File: rtl/sap1_datapath_if.sv
// Signal bundle between the SAP-1 controller/programmer and the datapath.
// The controller changes ctrl_word_i and hltn_i on the falling edge so they are stable at the next rising edge.
interface sap1_datapath_if #(
  parameter int DATA_W = 8
);
  logic [11:0]       ctrl_word_i;
  logic              hltn_i;
  logic              prog_we_i;
  logic [3:0]        prog_addr_i;
  logic [DATA_W-1:0] prog_data_i;
  logic [3:0]        opcode_o;
  logic [DATA_W-1:0] out_o;
  logic [DATA_W-1:0] bus_o;
  logic              carry_o;
  logic              zero_o;
  logic              bus_conflict_o;

  modport master (
    output ctrl_word_i, hltn_i, prog_we_i, prog_addr_i, prog_data_i,
    input  opcode_o, out_o, bus_o, carry_o, zero_o, bus_conflict_o
  );

  modport slave (
    input  ctrl_word_i, hltn_i, prog_we_i, prog_addr_i, prog_data_i,
    output opcode_o, out_o, bus_o, carry_o, zero_o, bus_conflict_o
  );
endinterface

// File: rtl/sap1_datapath.sv
// SAP-1 datapath: PC, MAR, 16-word RAM, IR, A, B, add/sub unit, OUT register and shared bus.
// All state updates on the rising edge when hltn_i is high; the RAM programming port ignores halt.
module sap1_datapath #(
  parameter int RAM_DEPTH = 16,
  parameter int DATA_W    = 8
) (
  input logic           clk_i,
  input logic           rstn_i,
  sap1_datapath_if.slave dp
);

  // Decoded control strobes, all active-high internally.
  logic incr_pc, pc_en, mar_load, ram_en, ir_load, ir_en;
  logic a_load, a_en, alu_en, alu_sub, b_load, out_load;

  assign incr_pc  =  dp.ctrl_word_i[0];
  assign pc_en    =  dp.ctrl_word_i[1];
  assign mar_load = ~dp.ctrl_word_i[2];
  assign ram_en   = ~dp.ctrl_word_i[3];
  assign ir_load  = ~dp.ctrl_word_i[4];
  assign ir_en    = ~dp.ctrl_word_i[5];
  assign a_load   = ~dp.ctrl_word_i[6];
  assign a_en     =  dp.ctrl_word_i[7];
  assign alu_en   =  dp.ctrl_word_i[8];
  assign alu_sub  =  dp.ctrl_word_i[9];
  assign b_load   = ~dp.ctrl_word_i[10];
  assign out_load = ~dp.ctrl_word_i[11];

  logic [3:0]        pc_q;
  logic [3:0]        mar_q;
  logic [DATA_W-1:0] ir_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [DATA_W-1:0] out_q;
  logic              carry_q;
  logic              zero_q;
  logic              conflict_q;

  logic [DATA_W-1:0] mem [RAM_DEPTH];
  logic [DATA_W-1:0] ram_rd;

  // RAM has no reset; the programming port writes regardless of halt.
  always_ff @(posedge clk_i) begin
    if (dp.prog_we_i) begin
      mem[dp.prog_addr_i] <= dp.prog_data_i;
    end
  end

  assign ram_rd = mem[mar_q];

  // Subtract is A + ~B + 1, so bit DATA_W is carry for add and not-borrow for subtract.
  logic [DATA_W-1:0] b_opnd;
  logic [DATA_W:0]   alu_sum;

  assign b_opnd  = alu_sub ? ~b_q : b_q;
  assign alu_sum = {1'b0, a_q} + {1'b0, b_opnd} + {{DATA_W{1'b0}}, alu_sub};

  logic [DATA_W-1:0] bus;

  always_comb begin
    bus = '0;
    if (pc_en) begin
      bus = {{(DATA_W-4){1'b0}}, pc_q};
    end else if (ram_en) begin
      bus = ram_rd;
    end else if (ir_en) begin
      bus = {{(DATA_W-4){1'b0}}, ir_q[3:0]};
    end else if (a_en) begin
      bus = a_q;
    end else if (alu_en) begin
      bus = alu_sum[DATA_W-1:0];
    end
  end

  // Two or more bits set means two or more bus drivers.
  logic [4:0] drivers;
  logic       multi_drive;

  assign drivers     = {pc_en, ram_en, ir_en, a_en, alu_en};
  assign multi_drive = |(drivers & (drivers - 5'd1));

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q       <= '0;
      mar_q      <= '0;
      ir_q       <= '0;
      a_q        <= '0;
      b_q        <= '0;
      out_q      <= '0;
      carry_q    <= 1'b0;
      zero_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else if (dp.hltn_i) begin
      if (incr_pc)  pc_q  <= pc_q + 4'd1;
      if (mar_load) mar_q <= bus[3:0];
      if (ir_load)  ir_q  <= bus;
      if (b_load)   b_q   <= bus;
      if (out_load) out_q <= bus;
      if (a_load) begin
        a_q <= bus;
        // Flags track only ALU results written into A.
        if (alu_en) begin
          carry_q <= alu_sum[DATA_W];
          zero_q  <= (alu_sum[DATA_W-1:0] == '0);
        end
      end
      if (multi_drive) conflict_q <= 1'b1;
    end
  end

  assign dp.opcode_o       = ir_q[DATA_W-1 -: 4];
  assign dp.out_o          = out_q;
  assign dp.bus_o          = bus;
  assign dp.carry_o        = carry_q;
  assign dp.zero_o         = zero_q;
  assign dp.bus_conflict_o = conflict_q;

endmodule

// File: tb/tb_sap1_datapath.sv
// Directed-plus-random bench for sap1_datapath; the bench acts as controller and programmer
// and predicts results from an instruction-level SAP-1 model.
module tb_sap1_datapath;

  localparam logic [11:0] IDLE  = 12'hC7C;
  localparam logic [11:0] INCR  = 12'h001;
  localparam logic [11:0] PCEN  = 12'h002;
  localparam logic [11:0] MARL  = 12'h004;
  localparam logic [11:0] RAMEN = 12'h008;
  localparam logic [11:0] IRL   = 12'h010;
  localparam logic [11:0] IREN  = 12'h020;
  localparam logic [11:0] AL    = 12'h040;
  localparam logic [11:0] AEN   = 12'h080;
  localparam logic [11:0] ALUEN = 12'h100;
  localparam logic [11:0] SUBM  = 12'h200;
  localparam logic [11:0] BL    = 12'h400;
  localparam logic [11:0] OUTL  = 12'h800;

  logic clk = 1'b0;
  logic rstn;

  sap1_datapath_if #(.DATA_W(8)) dp ();

  sap1_datapath #(.RAM_DEPTH(16), .DATA_W(8)) dut (
    .clk_i  (clk),
    .rstn_i (rstn),
    .dp     (dp.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Instruction-level reference state.
  logic [7:0] m_mem [16];
  logic [3:0] m_pc, m_mar;
  logic [7:0] m_a, m_b, m_out;
  logic       m_carry, m_zero, m_conf;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int alu_model(input logic [7:0] a, input logic [7:0] b, input logic sub);
    if (sub) return int'(a) + (255 - int'(b)) + 1;
    return int'(a) + int'(b);
  endfunction

  task automatic cyc(input logic [11:0] act);
    @(negedge clk);
    dp.ctrl_word_i = IDLE ^ act;
    @(posedge clk);
    #1;
  endtask

  task automatic peek(input logic [11:0] act, input string tag, input logic [7:0] exp);
    @(negedge clk);
    dp.ctrl_word_i = IDLE ^ act;
    #1;
    chk(tag, 32'(dp.bus_o), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    dp.ctrl_word_i = IDLE;
    dp.prog_we_i   = 1'b1;
    dp.prog_addr_i = a;
    dp.prog_data_i = d;
    @(posedge clk);
    #1;
    dp.prog_we_i = 1'b0;
    m_mem[a] = d;
  endtask

  task automatic set_halt(input logic v);
    @(negedge clk);
    dp.ctrl_word_i = IDLE;
    dp.hltn_i      = v;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_pc = '0; m_mar = '0; m_a = '0; m_b = '0; m_out = '0;
    m_carry = 1'b0; m_zero = 1'b0; m_conf = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    dp.ctrl_word_i = IDLE;
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
  endtask

  task automatic set_mar(input logic [3:0] k);
    prog_write(m_mar, {4'h0, k});
    cyc(RAMEN | MARL);
    m_mar = k;
  endtask

  task automatic load_a(input logic [7:0] v);
    set_mar(4'hF);
    prog_write(4'hF, v);
    cyc(RAMEN | AL);
    m_a = v;
  endtask

  task automatic load_b(input logic [7:0] v);
    set_mar(4'hF);
    prog_write(4'hF, v);
    cyc(RAMEN | BL);
    m_b = v;
  endtask

  task automatic alu_op(input logic sub, input string tag);
    int r;
    r = alu_model(m_a, m_b, sub);
    peek(ALUEN | (sub ? SUBM : 12'h000), {tag, "_bus"}, 8'(r));
    cyc(ALUEN | AL | (sub ? SUBM : 12'h000));
    m_a     = 8'(r);
    m_carry = r[8];
    m_zero  = (8'(r) == 8'h00);
    peek(AEN, {tag, "_a"}, m_a);
    chk({tag, "_carry"}, 32'(dp.carry_o), 32'(m_carry));
    chk({tag, "_zero"}, 32'(dp.zero_o), 32'(m_zero));
  endtask

  task automatic run_program(input logic [7:0] d9, input logic [7:0] da, input logic [7:0] db);
    logic [7:0] ir;
    logic       halted;
    int         r;
    do_reset();
    prog_write(4'h0, 8'h09);
    prog_write(4'h1, 8'h1A);
    prog_write(4'h2, 8'h2B);
    prog_write(4'h3, 8'hE0);
    prog_write(4'h4, 8'hF0);
    prog_write(4'h9, d9);
    prog_write(4'hA, da);
    prog_write(4'hB, db);
    halted = 1'b0;
    for (int n = 0; n < 8 && !halted; n++) begin
      cyc(PCEN | MARL);
      m_mar = m_pc;
      cyc(INCR);
      ir   = m_mem[m_pc];
      m_pc = m_pc + 4'd1;
      cyc(RAMEN | IRL);
      chk("prog_opcode", 32'(dp.opcode_o), 32'(ir[7:4]));
      case (ir[7:4])
        4'h0: begin
          cyc(IREN | MARL);
          cyc(RAMEN | AL);
          m_a = m_mem[ir[3:0]];
          cyc(12'h000);
        end
        4'h1, 4'h2: begin
          cyc(IREN | MARL);
          cyc(RAMEN | BL);
          m_b = m_mem[ir[3:0]];
          r = alu_model(m_a, m_b, ir[5]);
          cyc(ALUEN | AL | (ir[5] ? SUBM : 12'h000));
          m_a     = 8'(r);
          m_carry = r[8];
          m_zero  = (8'(r) == 8'h00);
          chk("prog_carry", 32'(dp.carry_o), 32'(m_carry));
          chk("prog_zero", 32'(dp.zero_o), 32'(m_zero));
        end
        4'hE: begin
          cyc(AEN | OUTL);
          m_out = m_a;
          chk("prog_out", 32'(dp.out_o), 32'(m_out));
        end
        default: halted = 1'b1;
      endcase
    end
    set_halt(1'b0);
    cyc(INCR | PCEN | MARL);
    chk("hlt_opcode", 32'(dp.opcode_o), 32'h0000000F);
    chk("hlt_out", 32'(dp.out_o), 32'(m_out));
    set_halt(1'b1);
    peek(AEN, "prog_a", m_a);
  endtask

  initial begin
    logic [7:0] ra, rb;
    logic       rs;
    int         n;

    rstn           = 1'b0;
    dp.ctrl_word_i = IDLE;
    dp.hltn_i      = 1'b1;
    dp.prog_we_i   = 1'b0;
    dp.prog_addr_i = '0;
    dp.prog_data_i = '0;
    model_reset();
    for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out", 32'(dp.out_o), 32'h0);
    chk("rst_opcode", 32'(dp.opcode_o), 32'h0);
    chk("rst_carry", 32'(dp.carry_o), 32'h0);
    chk("rst_zero", 32'(dp.zero_o), 32'h0);
    chk("rst_conflict", 32'(dp.bus_conflict_o), 32'h0);
    chk("rst_idle_bus", 32'(dp.bus_o), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    peek(AEN, "rst_a", 8'h00);

    // Reference program, then the same program with random operands.
    run_program(8'h10, 8'h14, 8'h18);
    chk("prog_out_const", 32'(dp.out_o), 32'h0C);
    for (int k = 0; k < 3; k++) begin
      run_program(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // ALU corner cases.
    load_a(8'hF0);
    load_b(8'h20);
    alu_op(1'b0, "add_ovf");
    chk("add_ovf_const", 32'(dp.carry_o), 32'h1);
    load_a(8'h05);
    load_b(8'h05);
    alu_op(1'b1, "sub_eq");
    chk("sub_eq_zero_const", 32'(dp.zero_o), 32'h1);
    load_a(8'h33);
    chk("ram_load_keeps_zero", 32'(dp.zero_o), 32'(m_zero));
    for (int k = 0; k < 8; k++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rs = 1'($urandom_range(0, 1));
      load_a(ra);
      load_b(rb);
      alu_op(rs, "alu_rand");
    end

    // PC wrap.
    do_reset();
    repeat (16) cyc(INCR);
    peek(PCEN, "pc_wrap0", 8'h00);
    cyc(INCR);
    peek(PCEN, "pc_wrap1", 8'h01);
    n = $urandom_range(1, 20);
    repeat (n) cyc(INCR);
    m_pc = 4'(1 + n);
    peek(PCEN, "pc_rand", {4'h0, m_pc});

    // Halt freezes registers but not the programming port.
    load_a(8'h3C);
    set_halt(1'b0);
    prog_write(4'hF, 8'h55);
    peek(RAMEN | AL, "halt_bus", 8'h55);
    cyc(INCR | RAMEN | OUTL);
    prog_write(4'h3, 8'hAA);
    set_halt(1'b1);
    peek(AEN, "halt_a_held", m_a);
    peek(PCEN, "halt_pc_held", {4'h0, m_pc});
    chk("halt_out_held", 32'(dp.out_o), 32'(m_out));
    set_mar(4'h3);
    peek(RAMEN, "halt_prog_ram3", 8'hAA);

    // Same-address write and read: old data until the edge.
    @(negedge clk);
    dp.ctrl_word_i = IDLE ^ RAMEN;
    dp.prog_we_i   = 1'b1;
    dp.prog_addr_i = 4'h3;
    dp.prog_data_i = 8'h3C;
    #1;
    chk("rw_old", 32'(dp.bus_o), 32'hAA);
    @(posedge clk);
    #1;
    dp.prog_we_i = 1'b0;
    m_mem[3] = 8'h3C;
    chk("rw_new", 32'(dp.bus_o), 32'h3C);

    // Self load/drive is not a conflict; two drivers is, and it sticks.
    cyc(AEN | AL);
    chk("self_load_noconf", 32'(dp.bus_conflict_o), 32'h0);
    peek(AEN, "self_load_a", m_a);
    peek(PCEN | RAMEN, "conf_bus", {4'h0, m_pc});
    chk("conf_set", 32'(dp.bus_conflict_o), 32'h1);
    repeat (3) cyc(12'h000);
    chk("conf_sticky", 32'(dp.bus_conflict_o), 32'h1);

    // Populate outputs, then reset mid-cycle.
    load_a(8'h77);
    cyc(AEN | OUTL);
    cyc(RAMEN | IRL);
    chk("pre_rst_out", 32'(dp.out_o), 32'h77);
    chk("pre_rst_opcode", 32'(dp.opcode_o), 32'h7);
    load_b(8'h77);
    alu_op(1'b1, "pre_rst_sub");
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    chk("midrst_out", 32'(dp.out_o), 32'h0);
    chk("midrst_opcode", 32'(dp.opcode_o), 32'h0);
    chk("midrst_carry", 32'(dp.carry_o), 32'h0);
    chk("midrst_zero", 32'(dp.zero_o), 32'h0);
    chk("midrst_conflict", 32'(dp.bus_conflict_o), 32'h0);
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    peek(AEN, "midrst_a", 8'h00);
    peek(PCEN, "midrst_pc", 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sap1_datapath.md
# sap1_datapath

SAP-1 datapath: program counter, memory address register, 16x8 RAM, instruction register, accumulator A, B register, add/subtract unit, output register and the shared 8-bit bus. It consumes the 12-bit control word and the halt signal from the controller and returns the current opcode to it. A programming port loads RAM before or between runs.

## Interface
Parameters:
- RAM_DEPTH, 16, words of RAM (address width fixed at 4).
- DATA_W, 8, bus and register width.

Ports (one clock; reset is asynchronous and active-low):
- clk_i  input  1  clock; all datapath registers update on the rising edge.
- rstn_i  input  1  asynchronous active-low reset.
- ctrl_word_i  input  12  control word from the controller.
- hltn_i  input  1  halt, active-low; low freezes all register updates.
- prog_we_i  input  1  RAM write strobe from the programming port.
- prog_addr_i  input  4  RAM write address.
- prog_data_i  input  8  RAM write data.
- opcode_o  output  4  IR[7:4], returned to the controller.
- out_o  output  8  output register.
- bus_o  output  8  current bus value, for debug.
- carry_o  output  1  registered carry/borrow flag.
- zero_o  output  1  registered zero flag.
- bus_conflict_o  output  1  sticky flag: more than one bus driver seen at a clock edge.

## Operation
Control word bit map and polarity:
- bit 0, INCR_PC, active-high.
- bit 1, PC_EN, active-high.
- bit 2, MAR_LOAD, active-low.
- bit 3, RAM_EN, active-low.
- bit 4, INSTR_LOAD, active-low.
- bit 5, INSTR_EN, active-low.
- bit 6, A_ACC_LOAD, active-low.
- bit 7, A_ACC_EN, active-high.
- bit 8, ADD_SUB_LOAD (ALU result onto bus), active-high.
- bit 9, ADD_SUB_EN (1 = subtract), active-high.
- bit 10, B_REG_LOAD, active-low.
- bit 11, OUT_REG_LOAD, active-low.

Bus drivers are combinational:
- PC drives {4'h0, PC}.
- RAM drives RAM[MAR].
- IR drives {4'h0, IR[3:0]}.
- A drives A.
- ALU drives its 8-bit result.
- Fixed priority when several are enabled: PC > RAM > IR > A > ALU.
- No driver enabled: bus = 8'h00.

Register updates on the rising edge of clk_i, only when hltn_i = 1:
- PC: increments when INCR_PC = 1; 4-bit, wraps 15 -> 0.
- MAR <= bus[3:0] when MAR_LOAD = 0.
- IR <= bus when INSTR_LOAD = 0.
- A <= bus when A_ACC_LOAD = 0.
- B <= bus when B_REG_LOAD = 0.
- OUT <= bus when OUT_REG_LOAD = 0.
- Flags: when A loads while ADD_SUB_LOAD = 1:
  - carry_o <= bit 8 of the 9-bit result (borrow = NOT carry for subtract).
  - zero_o <= (result == 0).
  - A load from any other source leaves the flags unchanged.

ALU:
- Add: A + B.
- Subtract: A + ~B + 1.
- Result is truncated to 8 bits and wraps.

RAM:
- Read is combinational from MAR.
- Write occurs only through the programming port, on the rising edge, whenever prog_we_i = 1, regardless of hltn_i.
- If a write and a read target the same address in the same cycle, the bus shows the old data; the new data is visible from the next cycle.

bus_conflict_o:
- Sets when two or more drivers are enabled at a rising edge with hltn_i = 1.
- Clears only on reset.

## Timing
- Reset: PC, MAR, IR, A, B, OUT, carry_o, zero_o and bus_conflict_o all go to 0 asynchronously; opcode_o = 0 and out_o = 0. RAM contents are not reset.
- Reset asserted mid-instruction clears all registers immediately. The first rising edge after deassertion uses whatever control word is present.
- The controller changes the control word on the falling edge, so each control word is stable for the following rising edge. Every load and increment therefore has 1-edge latency.
- opcode_o follows IR combinationally; it is valid 1 edge after the INSTR_LOAD edge.
- With hltn_i = 0, all registers hold their values. The bus and opcode_o stay combinational and the programming port stays active.
- A simultaneous load and drive of the same register (for example A_ACC_EN with A_ACC_LOAD low) loads its own value: no change, no conflict.

## Test plan
- Program RAM with 0x09, 0x1A, 0x2B, 0xE0, 0xF0 at addresses 0-4, and 0x10, 0x14, 0x18 at addresses 9, A, B. Drive the controller's fetch/execute control-word sequence -> after OUT: out_o = 0x0C and A = 0x0C; at HLT, opcode_o = 0xF.
- Set A = 0xF0, B = 0x20, add with A load -> A = 0x10, carry_o = 1, zero_o = 0.
- Set A = 0x05, B = 0x05, subtract with A load -> A = 0x00, zero_o = 1, carry_o = 1.
- Pulse INCR_PC 17 times -> PC passes 15 -> 0 and ends at 1; bus shows 0x01 with PC_EN = 1.
- With hltn_i = 0, drive A_ACC_LOAD low with RAM data 0x55 -> A unchanged. Then a programming write to address 3 with 0xAA -> RAM[3] = 0xAA.
- Enable PC_EN and RAM_EN = 0 together -> bus = PC value and bus_conflict_o = 1. The flag stays 1 until rstn_i pulses low; mid-run reset zeroes all outputs.
